// File: rtl/fht_io_seq.sv
// fht_io_seq: host-side sequencer that loads ADC samples into fht_top, starts the transform and unloads the results.
//
// Ports:
//    iCLK, iRESET          clock, asynchronous active-low reset
//    iARM                  start one load/transform/unload cycle (sampled in IDLE)
//    iABORT                synchronous return to IDLE from any state
//    iADC_VALID/iADC_DATA  ADC sample stream
//    oDATA, oADDR_WR_0..3, oWE_0..3   fht_top write ports (registered)
//    oSTART                one-cycle transform start pulse
//    iFHT_RDY              fht_top done flag (a rising edge ends WAIT)
//    oADDR_RD_0..3, iRE_0..3          fht_top read ports (1-cycle read latency)
//    oOUT_VALID/oOUT_DATA/oOUT_INDEX/oOUT_LAST, iOUT_READY   result stream
//    oBUSY                 high outside IDLE
//    oOVF                  sticky: sample arrived while busy but not loading
//
// Build option: define FHT_BITREV_EN to read in base-4 digit-reversed order,
// so results leave in natural frequency order.
module fht_io_seq #(
   parameter int A_BIT = 8,
   parameter int D_BIT = 17
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iARM,
   input  logic             iABORT,
   input  logic             iADC_VALID,
   input  logic [D_BIT-2:0] iADC_DATA,
   output logic [D_BIT-2:0] oDATA,
   output logic [A_BIT-1:0] oADDR_WR_0,
   output logic [A_BIT-1:0] oADDR_WR_1,
   output logic [A_BIT-1:0] oADDR_WR_2,
   output logic [A_BIT-1:0] oADDR_WR_3,
   output logic             oWE_0,
   output logic             oWE_1,
   output logic             oWE_2,
   output logic             oWE_3,
   output logic [A_BIT-1:0] oADDR_RD_0,
   output logic [A_BIT-1:0] oADDR_RD_1,
   output logic [A_BIT-1:0] oADDR_RD_2,
   output logic [A_BIT-1:0] oADDR_RD_3,
   output logic             oSTART,
   input  logic             iFHT_RDY,
   input  logic [D_BIT-1:0] iRE_0,
   input  logic [D_BIT-1:0] iRE_1,
   input  logic [D_BIT-1:0] iRE_2,
   input  logic [D_BIT-1:0] iRE_3,
   output logic             oOUT_VALID,
   output logic [D_BIT-1:0] oOUT_DATA,
   output logic [A_BIT+1:0] oOUT_INDEX,
   output logic             oOUT_LAST,
   input  logic             iOUT_READY,
   output logic             oBUSY,
   output logic             oOVF
);
   localparam int I = A_BIT + 2;
   localparam logic [I-1:0] LAST = '1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_UNLOAD} state_t;

   state_t                 state_q, state_d;
   logic [I-1:0]           n_q, n_d;
   logic                   full_q, full_d;
   logic [3:0]             we_q, we_d;
   logic [A_BIT-1:0]       addr_wr_q, addr_wr_d;
   logic [D_BIT-2:0]       data_q, data_d;
   logic                   rdy_q;
   logic                   ovf_q, ovf_d;
   logic [I-1:0]           rd_j_q, rd_j_d;
   logic                   rd_done_q, rd_done_d;
   logic                   infl_q, infl_d;
   logic [1:0]             sel_q, sel_d;
   logic [1:0][D_BIT-1:0]  mem_q, mem_d;
   logic                   wp_q, wp_d, rp_q, rp_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [I-1:0]           out_j_q, out_j_d;

   logic [I-1:0]           rd_p;
   logic [D_BIT-1:0]       rdata;
   logic [1:0]             occ;
   logic                   out_valid, pop, push, issue;

`ifdef FHT_BITREV_EN
   for (genvar d = 0; d < I/2; d++) begin : g_rev
      assign rd_p[2*d +: 2] = rd_j_q[I-2-2*d +: 2];
   end
`else
   assign rd_p = rd_j_q;
`endif

   assign rdata     = sel_q[1] ? (sel_q[0] ? iRE_3 : iRE_2) : (sel_q[0] ? iRE_1 : iRE_0);
   assign out_valid = cnt_q != 2'd0;
   assign pop       = out_valid & iOUT_READY;
   assign push      = infl_q;
   // Occupancy after this cycle's pop, so a steady stream sustains one result per cycle
   // while FIFO entries plus reads in flight never exceed two.
   assign occ       = cnt_q - {1'b0, pop};
   assign issue     = state_q == S_UNLOAD && !rd_done_q && (occ + {1'b0, infl_q}) < 2'd2;

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      full_d    = full_q;
      we_d      = '0;
      addr_wr_d = addr_wr_q;
      data_d    = data_q;
      ovf_d     = ovf_q;
      rd_j_d    = rd_j_q;
      rd_done_d = rd_done_q;
      infl_d    = 1'b0;
      sel_d     = sel_q;
      mem_d     = mem_q;
      wp_d      = wp_q;
      rp_d      = rp_q;
      cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
      out_j_d   = out_j_q;
      if (iADC_VALID && state_q != S_IDLE && state_q != S_LOAD)
         ovf_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (iARM) begin
               state_d   = S_LOAD;
               n_d       = '0;
               full_d    = 1'b0;
               ovf_d     = 1'b0;
               rd_j_d    = '0;
               rd_done_d = 1'b0;
               out_j_d   = '0;
            end
         end
         S_LOAD: begin
            if (iADC_VALID && !full_q) begin
               we_d[n_q[1:0]] = 1'b1;
               addr_wr_d      = n_q[I-1:2];
               data_d         = iADC_DATA;
               n_d            = (n_q == LAST) ? n_q : n_q + 1'b1;
               full_d         = n_q == LAST;
            end
            // Leave only once the final write has been presented, so WE never overlaps KICK.
            if (full_q)
               state_d = S_KICK;
         end
         S_KICK:
            state_d = S_WAIT;
         S_WAIT: begin
            // Edge detect: a level left high from before KICK does not count as done.
            if (iFHT_RDY && !rdy_q)
               state_d = S_UNLOAD;
         end
         S_UNLOAD: begin
            if (issue) begin
               sel_d     = rd_p[1:0];
               infl_d    = 1'b1;
               rd_j_d    = (rd_j_q == LAST) ? rd_j_q : rd_j_q + 1'b1;
               rd_done_d = rd_j_q == LAST;
            end
            if (pop && out_j_q == LAST)
               state_d = S_IDLE;
         end
         default:
            state_d = S_IDLE;
      endcase
      if (push) begin
         mem_d[wp_q] = rdata;
         wp_d        = ~wp_q;
      end
      if (pop) begin
         rp_d    = ~rp_q;
         out_j_d = (out_j_q == LAST) ? '0 : out_j_q + 1'b1;
      end
      if (iABORT) begin
         state_d = S_IDLE;
         we_d    = '0;
         ovf_d   = ovf_q;
         infl_d  = 1'b0;
         cnt_d   = '0;
         wp_d    = 1'b0;
         rp_d    = 1'b0;
      end
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         full_q    <= 1'b0;
         we_q      <= '0;
         addr_wr_q <= '0;
         data_q    <= '0;
         rdy_q     <= 1'b0;
         ovf_q     <= 1'b0;
         rd_j_q    <= '0;
         rd_done_q <= 1'b0;
         infl_q    <= 1'b0;
         sel_q     <= '0;
         mem_q     <= '0;
         wp_q      <= 1'b0;
         rp_q      <= 1'b0;
         cnt_q     <= '0;
         out_j_q   <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         full_q    <= full_d;
         we_q      <= we_d;
         addr_wr_q <= addr_wr_d;
         data_q    <= data_d;
         rdy_q     <= iFHT_RDY;
         ovf_q     <= ovf_d;
         rd_j_q    <= rd_j_d;
         rd_done_q <= rd_done_d;
         infl_q    <= infl_d;
         sel_q     <= sel_d;
         mem_q     <= mem_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         cnt_q     <= cnt_d;
         out_j_q   <= out_j_d;
      end
   end

   assign oDATA      = data_q;
   assign oADDR_WR_0 = addr_wr_q;
   assign oADDR_WR_1 = addr_wr_q;
   assign oADDR_WR_2 = addr_wr_q;
   assign oADDR_WR_3 = addr_wr_q;
   assign oWE_0      = we_q[0];
   assign oWE_1      = we_q[1];
   assign oWE_2      = we_q[2];
   assign oWE_3      = we_q[3];
   assign oADDR_RD_0 = rd_p[I-1:2];
   assign oADDR_RD_1 = rd_p[I-1:2];
   assign oADDR_RD_2 = rd_p[I-1:2];
   assign oADDR_RD_3 = rd_p[I-1:2];
   assign oSTART     = state_q == S_KICK;
   assign oOUT_VALID = out_valid;
   assign oOUT_DATA  = mem_q[rp_q];
   assign oOUT_INDEX = out_j_q;
   assign oOUT_LAST  = out_valid && out_j_q == LAST;
   assign oBUSY      = state_q != S_IDLE;
   assign oOVF       = ovf_q;
endmodule
